common_dffram_fifo_ctrl: RTL and testbench

Sequencing controller that turns a 2-address/1-write/2-read DFF RAM (binary addressing, no bit write-enable) into a synchronous first-word-fall-through FIFO.
- Owns the write pointer (drives RAM port A, write-only use) and the read pointer (drives RAM port B, combinational read).
- Provides valid/ready push and pop interfaces, occupancy, full/empty/almost-full flags, and a synchronous flush.
- Does not instantiate the RAM. The parent instantiates the RAM with RAM_DEPTH=FIFO_DEPTH and RAM_WIDTH=FIFO_WIDTH and connects the ram_* ports.

---
 rtl/common_dffram_fifo_ctrl_pkg.sv | 17 +
 rtl/common_dffram_fifo_ptr.sv | 29 ++
 rtl/common_dffram_fifo_ctrl.sv | 91 +++++++++
 tb/tb_common_dffram_fifo_ctrl.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/common_dffram_fifo_ctrl_pkg.sv
// Shared types and helpers for the DFF-RAM FIFO controller and its pointer counters.
package common_dffram_fifo_ctrl_pkg;

    // Encoded {push, pop} pair driving the occupancy update.
    typedef enum logic [1:0] {
        OpIdle = 2'b00,
        OpPop  = 2'b01,
        OpPush = 2'b10,
        OpBoth = 2'b11
    } fifo_op_e;

    // Increment that wraps to zero after depth-1 (depth need not be a power of two).
    function automatic int unsigned wrap_inc(input int unsigned ptr, input int unsigned depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/common_dffram_fifo_ptr.sv
// Wrap-at-DEPTH-1 pointer counter with synchronous clear; reset wins over clear.
module common_dffram_fifo_ptr
    import common_dffram_fifo_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             inc,
    output logic [PTR_W-1:0] ptr
);

    logic [PTR_W-1:0] ptr_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= '0;
        end else if (clear) begin
            ptr_q <= '0;
        end else if (inc) begin
            ptr_q <= PTR_W'(wrap_inc(32'(ptr_q), DEPTH));
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/common_dffram_fifo_ctrl.sv
// Turns an external 1W/2R DFF RAM into a first-word-fall-through FIFO: pointers, occupancy,
// flags and valid/ready handshakes. The RAM itself lives in the parent.
module common_dffram_fifo_ctrl
    import common_dffram_fifo_ctrl_pkg::*;
#(
    parameter int unsigned FIFO_WIDTH  = 8,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned AFULL_LEVEL = FIFO_DEPTH - 1,
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH),
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [FIFO_WIDTH-1:0] s_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [FIFO_WIDTH-1:0] m_data,
    output logic [CNT_W-1:0]      count,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_full,
    output logic [PTR_W-1:0]      ram_addra,
    output logic                  ram_ena,
    output logic                  ram_wea,
    output logic [FIFO_WIDTH-1:0] ram_dina,
    output logic [PTR_W-1:0]      ram_addrb,
    input  logic [FIFO_WIDTH-1:0] ram_doutb
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             push, pop;
    fifo_op_e         op;

    assign empty       = (cnt_q == '0);
    assign full        = (cnt_q == CNT_W'(FIFO_DEPTH));
    assign almost_full = (cnt_q >= CNT_W'(AFULL_LEVEL));
    assign count       = cnt_q;

    // Flush and reset gate both handshakes so no RAM write or pop can slip through.
    assign s_ready = !full && !flush && !reset;
    assign m_valid = !empty && !flush && !reset;
    assign push    = s_valid && s_ready;
    assign pop     = m_valid && m_ready;
    assign op      = fifo_op_e'({push, pop});

    assign ram_ena  = push;
    assign ram_wea  = push;
    assign ram_dina = s_data;
    assign m_data   = ram_doutb;

    always_comb begin
        cnt_d = cnt_q;
        unique case (op)
            OpPush:  cnt_d = cnt_q + CNT_W'(1);
            OpPop:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    common_dffram_fifo_ptr #(
        .DEPTH(FIFO_DEPTH)
    ) u_wptr (
        .clk  (clk),
        .reset(reset),
        .clear(flush),
        .inc  (push),
        .ptr  (ram_addra)
    );

    common_dffram_fifo_ptr #(
        .DEPTH(FIFO_DEPTH)
    ) u_rptr (
        .clk  (clk),
        .reset(reset),
        .clear(flush),
        .inc  (pop),
        .ptr  (ram_addrb)
    );

endmodule

// File: tb/tb_common_dffram_fifo_ctrl.sv
// Directed bench for the FIFO controller with a behavioural 3-entry DFF RAM attached.
module tb_common_dffram_fifo_ctrl;

    localparam int unsigned W = 8;
    localparam int unsigned D = 3;
    localparam int unsigned AF = 2;
    localparam int unsigned PW = $clog2(D);
    localparam int unsigned CW = $clog2(D + 1);

    logic          clk = 1'b0;
    logic          reset, flush, s_valid, s_ready, m_valid, m_ready;
    logic [W-1:0]  s_data, m_data, ram_dina, ram_doutb;
    logic [CW-1:0] count;
    logic          empty, full, almost_full, ram_ena, ram_wea;
    logic [PW-1:0] ram_addra, ram_addrb;
    logic [W-1:0]  mem [D];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    common_dffram_fifo_ctrl #(
        .FIFO_WIDTH (W),
        .FIFO_DEPTH (D),
        .AFULL_LEVEL(AF)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .count      (count),
        .empty      (empty),
        .full       (full),
        .almost_full(almost_full),
        .ram_addra  (ram_addra),
        .ram_ena    (ram_ena),
        .ram_wea    (ram_wea),
        .ram_dina   (ram_dina),
        .ram_addrb  (ram_addrb),
        .ram_doutb  (ram_doutb)
    );

    always @(posedge clk) begin
        if (ram_ena && ram_wea) mem[ram_addra] <= ram_dina;
    end
    assign ram_doutb = mem[ram_addrb];

    typedef struct {
        logic       rst, fl, sv;
        logic [7:0] sd;
        logic       mr;
        logic       srdy, mv;
        logic [7:0] md;
        logic [1:0] cnt;
        logic       af;
        logic [1:0] wa, ra;
    } vec_t;

    vec_t vecs [21];

    function automatic vec_t mk(input logic rst, fl, sv, input logic [7:0] sd, input logic mr,
                                input logic srdy, mv, input logic [7:0] md,
                                input logic [1:0] cnt, input logic af,
                                input logic [1:0] wa, ra);
        vec_t v;
        v.rst = rst; v.fl = fl; v.sv = sv; v.sd = sd; v.mr = mr;
        v.srdy = srdy; v.mv = mv; v.md = md; v.cnt = cnt; v.af = af; v.wa = wa; v.ra = ra;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, fl, sv, input logic [7:0] sd, input logic mr);
        reset = rst; flush = fl; s_valid = sv; s_data = sd; m_ready = mr;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] exp_q [$];
    int         budget;

    initial begin
        // rst fl sv sd mr | srdy mv md cnt af wa ra
        vecs[0]  = mk(1, 0, 1, 8'h11, 0, 0, 0, 8'h00, 0, 0, 0, 0);
        vecs[1]  = mk(0, 0, 1, 8'h11, 0, 1, 0, 8'h00, 0, 0, 0, 0);
        vecs[2]  = mk(0, 0, 1, 8'h22, 0, 1, 1, 8'h11, 1, 0, 1, 0);
        vecs[3]  = mk(0, 0, 1, 8'h33, 0, 1, 1, 8'h11, 2, 1, 2, 0);
        vecs[4]  = mk(0, 0, 0, 8'h00, 0, 0, 1, 8'h11, 3, 1, 0, 0);
        vecs[5]  = mk(0, 0, 1, 8'h44, 1, 0, 1, 8'h11, 3, 1, 0, 0);
        vecs[6]  = mk(0, 0, 1, 8'h44, 1, 1, 1, 8'h22, 2, 1, 0, 1);
        vecs[7]  = mk(0, 0, 0, 8'h00, 1, 1, 1, 8'h33, 2, 1, 1, 2);
        vecs[8]  = mk(0, 0, 0, 8'h00, 1, 1, 1, 8'h44, 1, 0, 1, 0);
        vecs[9]  = mk(0, 1, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 1, 1);
        vecs[10] = mk(0, 0, 1, 8'hA5, 0, 1, 0, 8'h00, 0, 0, 0, 0);
        vecs[11] = mk(0, 0, 0, 8'h00, 0, 1, 1, 8'hA5, 1, 0, 1, 0);
        vecs[12] = mk(0, 0, 1, 8'h5A, 1, 1, 1, 8'hA5, 1, 0, 1, 0);
        vecs[13] = mk(0, 0, 1, 8'h66, 0, 1, 1, 8'h5A, 1, 0, 2, 1);
        vecs[14] = mk(0, 1, 1, 8'h77, 1, 0, 0, 8'h00, 2, 1, 0, 1);
        vecs[15] = mk(0, 0, 0, 8'h00, 0, 1, 0, 8'h00, 0, 0, 0, 0);
        vecs[16] = mk(0, 0, 1, 8'h88, 0, 1, 0, 8'h00, 0, 0, 0, 0);
        vecs[17] = mk(0, 0, 1, 8'h99, 0, 1, 1, 8'h88, 1, 0, 1, 0);
        vecs[18] = mk(1, 0, 1, 8'hAA, 1, 0, 0, 8'h00, 2, 1, 2, 0);
        vecs[19] = mk(0, 0, 1, 8'h77, 0, 1, 0, 8'h00, 0, 0, 0, 0);
        vecs[20] = mk(0, 0, 0, 8'h00, 0, 1, 1, 8'h77, 1, 0, 1, 0);

        drive(1, 0, 0, 8'h00, 0);
        next_cycle();
        next_cycle();

        for (int i = 0; i < 21; i++) begin
            drive(vecs[i].rst, vecs[i].fl, vecs[i].sv, vecs[i].sd, vecs[i].mr);
            @(negedge clk);
            check($sformatf("v%0d s_ready", i), 32'(s_ready), 32'(vecs[i].srdy));
            check($sformatf("v%0d m_valid", i), 32'(m_valid), 32'(vecs[i].mv));
            if (vecs[i].mv) check($sformatf("v%0d m_data", i), 32'(m_data), 32'(vecs[i].md));
            check($sformatf("v%0d count", i), 32'(count), 32'(vecs[i].cnt));
            check($sformatf("v%0d empty", i), 32'(empty), 32'(vecs[i].cnt == 2'd0));
            check($sformatf("v%0d full", i), 32'(full), 32'(vecs[i].cnt == 2'd3));
            check($sformatf("v%0d almost_full", i), 32'(almost_full), 32'(vecs[i].af));
            check($sformatf("v%0d ram_addra", i), 32'(ram_addra), 32'(vecs[i].wa));
            check($sformatf("v%0d ram_addrb", i), 32'(ram_addrb), 32'(vecs[i].ra));
            check($sformatf("v%0d ram_wea", i), 32'(ram_wea), 32'(vecs[i].sv & vecs[i].srdy));
            check($sformatf("v%0d ram_ena", i), 32'(ram_ena), 32'(vecs[i].sv & vecs[i].srdy));
            check($sformatf("v%0d ram_dina", i), 32'(ram_dina), 32'(vecs[i].sd));
            next_cycle();
        end

        // FIFO holds 0x77; fill to full, then stall a held push while the head stays put.
        exp_q.push_back(8'h77);
        drive(0, 0, 1, 8'hB1, 0);
        next_cycle();
        exp_q.push_back(8'hB1);
        drive(0, 0, 1, 8'hB2, 0);
        next_cycle();
        exp_q.push_back(8'hB2);
        drive(0, 0, 1, 8'hC3, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("hold%0d s_ready", i), 32'(s_ready), 32'd0);
            check($sformatf("hold%0d m_data", i), 32'(m_data), 32'h77);
            check($sformatf("hold%0d count", i), 32'(count), 32'd3);
            check($sformatf("hold%0d full", i), 32'(full), 32'd1);
            next_cycle();
        end

        // Drain with a bounded budget; popped order must match push order.
        drive(0, 0, 0, 8'h00, 1);
        budget = 10;
        @(negedge clk);
        while (m_valid && budget > 0) begin
            if (exp_q.size() == 0) begin
                check("drain extra pop", 32'd1, 32'd0);
            end else begin
                check("drain m_data", 32'(m_data), 32'(exp_q.pop_front()));
            end
            budget--;
            next_cycle();
            @(negedge clk);
        end
        check("drain budget left", 32'(budget > 0), 32'd1);
        check("drain remaining", 32'(exp_q.size()), 32'd0);
        check("drain empty", 32'(empty), 32'd1);
        check("drain count", 32'(count), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
